// File: rtl/counter_pkg.sv
// Shared constants for the programmable counter: direction/mode encodings
// and default widths.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int CNT_W_DEF = 16;
  localparam int PRE_W_DEF = 8;

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits one step per (pre_div+1) enabled cycles; phase
// holds while count_en is low and restarts on sync_clr.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             sync_clr,
  input  logic [PRE_W-1:0] pre_div,
  output logic             step
);

  logic [PRE_W-1:0] r_pre_cnt;
  logic             w_period_end;

  // >= rather than == so lowering pre_div below the running phase ends the period at once
  assign w_period_end = (r_pre_cnt >= pre_div);
  assign step         = count_en && w_period_end && !sync_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= '0;
    end else if (sync_clr) begin
      r_pre_cnt <= '0;
    end else if (count_en) begin
      r_pre_cnt <= w_period_end ? '0 : r_pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_prog.sv
// Programmable up/down counter with load, terminal limit, wrap/saturate,
// prescaled enable, compare match and sticky overflow.
module counter_prog
  import counter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             count_en,
  input  logic             count_clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dir,
  input  logic             mode,
  input  logic [CNT_W-1:0] limit,
  input  logic [PRE_W-1:0] pre_div,
  input  logic [CNT_W-1:0] cmp_val,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] count,
  output logic             tick,
  output logic             ovf_flag,
  output logic             cmp_match,
  output logic             at_term
);

  logic [CNT_W-1:0] r_count;
  logic             r_tick;
  logic             r_ovf;
  logic [CNT_W-1:0] w_count_next;
  logic             w_tick_next;
  logic             w_ovf_next;
  logic             w_step;

  counter_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .count_en (count_en),
    .sync_clr (count_clr | load),
    .pre_div  (pre_div),
    .step     (w_step)
  );

  always_comb begin
    w_count_next = r_count;
    w_tick_next  = 1'b0;
    if (count_clr) begin
      w_count_next = '0;
    end else if (load) begin
      w_count_next = (load_val > limit) ? limit : load_val;
    end else if (w_step) begin
      if (dir == DIR_UP) begin
        if (r_count < limit) begin
          w_count_next = r_count + 1'b1;
        end else begin
          // saturate also pulls an over-limit count back down to limit
          w_tick_next  = 1'b1;
          w_count_next = (mode == MODE_WRAP) ? '0 : limit;
        end
      end else begin
        if (r_count != '0) begin
          w_count_next = r_count - 1'b1;
        end else begin
          w_tick_next  = 1'b1;
          w_count_next = (mode == MODE_WRAP) ? limit : '0;
        end
      end
    end
  end

  // a new terminal event outranks a clear request in the same cycle
  assign w_ovf_next = w_tick_next ? 1'b1 : (ovf_clr ? 1'b0 : r_ovf);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_tick  <= w_tick_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign count     = r_count;
  assign tick      = r_tick;
  assign ovf_flag  = r_ovf;
  assign cmp_match = (r_count == cmp_val);
  assign at_term   = (dir == DIR_UP) ? (r_count >= limit) : (r_count == '0);

endmodule

// File: tb/tb_counter_prog.sv
// Directed plus randomized bench for counter_prog (CNT_W=8, PRE_W=4) with a
// behavioural reference model feeding an expectation queue.
module tb_counter_prog;

  localparam int CW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst, count_en, count_clr, load, dir, mode, ovf_clr;
  logic [CW-1:0] load_val, limit, cmp_val;
  logic [PW-1:0] pre_div;
  logic [CW-1:0] count;
  logic          tick, ovf_flag, cmp_match, at_term;

  typedef struct {
    logic [CW-1:0] cnt;
    logic          tck;
    logic          ovf;
    logic          cmp;
    logic          trm;
  } exp_t;

  exp_t sb_q[$];

  logic [CW-1:0] m_count;
  logic [PW-1:0] m_pre;
  logic          m_tick, m_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  counter_prog #(.CNT_W(CW), .PRE_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_en  (count_en),
    .count_clr (count_clr),
    .load      (load),
    .load_val  (load_val),
    .dir       (dir),
    .mode      (mode),
    .limit     (limit),
    .pre_div   (pre_div),
    .cmp_val   (cmp_val),
    .ovf_clr   (ovf_clr),
    .count     (count),
    .tick      (tick),
    .ovf_flag  (ovf_flag),
    .cmp_match (cmp_match),
    .at_term   (at_term)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: advance one clock using the inputs currently driven.
  task automatic model_update();
    logic st;
    st = 1'b0;
    if (rst) begin
      m_count = '0; m_pre = '0; m_tick = 1'b0; m_ovf = 1'b0;
    end else begin
      if (count_clr) begin
        m_count = '0; m_pre = '0; m_tick = 1'b0;
      end else if (load) begin
        m_count = (load_val > limit) ? limit : load_val;
        m_pre = '0; m_tick = 1'b0;
      end else begin
        if (count_en) begin
          if (m_pre >= pre_div) begin st = 1'b1; m_pre = '0; end
          else m_pre = m_pre + 1'b1;
        end
        m_tick = 1'b0;
        if (st && dir) begin
          if (m_count < limit) m_count = m_count + 1'b1;
          else begin m_tick = 1'b1; if (!mode) m_count = '0; else m_count = limit; end
        end else if (st && !dir) begin
          if (m_count > 0) m_count = m_count - 1'b1;
          else begin m_tick = 1'b1; if (!mode) m_count = limit; end
        end
      end
      if (m_tick) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  endtask

  task automatic cyc();
    exp_t e;
    model_update();
    e.cnt = m_count;
    e.tck = m_tick;
    e.ovf = m_ovf;
    e.cmp = (m_count == cmp_val);
    e.trm = dir ? (m_count >= limit) : (m_count == 0);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("count", count, e.cnt);
    chk("tick", tick, e.tck);
    chk("ovf_flag", ovf_flag, e.ovf);
    chk("cmp_match", cmp_match, e.cmp);
    chk("at_term", at_term, e.trm);
  endtask

  initial begin
    m_count = '0; m_pre = '0; m_tick = 1'b0; m_ovf = 1'b0;
    rst = 1'b1; count_en = 1'b0; count_clr = 1'b0; load = 1'b0; ovf_clr = 1'b0;
    dir = 1'b1; mode = 1'b0; load_val = '0; limit = 8'd5; cmp_val = 8'd3; pre_div = '0;
    @(posedge clk); #1;
    cyc();
    chk("rst_count", count, 0);
    chk("rst_tick", tick, 0);
    chk("rst_ovf", ovf_flag, 0);

    // up-wrap at limit 5
    rst = 1'b0; count_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("wrap_seq", count, (i + 1) % 6);
      chk("wrap_tick", tick, (i == 5) ? 1 : 0);
    end
    chk("wrap_ovf", ovf_flag, 1);

    // clear flag, then down-saturate from a loaded 2
    count_en = 1'b0; ovf_clr = 1'b1;
    cyc();
    chk("ovf_cleared", ovf_flag, 0);
    ovf_clr = 1'b0; dir = 1'b0; mode = 1'b1; load = 1'b1; load_val = 8'd2; count_en = 1'b1;
    cyc();
    chk("load2", count, 2);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("sat_down", count, (i == 0) ? 1 : 0);
      chk("sat_tick", tick, (i >= 2) ? 1 : 0);
    end

    // prescaler /4 with an enable gap mid-period
    count_clr = 1'b1; cyc(); count_clr = 1'b0;
    dir = 1'b1; mode = 1'b0; limit = 8'd255; pre_div = 4'd3; count_en = 1'b1;
    for (int i = 0; i < 14; i++) cyc();
    chk("pre_cnt3", count, 3);
    count_en = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    count_en = 1'b1;
    cyc();
    chk("pre_hold", count, 3);
    cyc();
    chk("pre_resume", count, 4);

    // load clamp, terminal and compare
    limit = 8'd100; cmp_val = 8'd100; load = 1'b1; load_val = 8'd200;
    cyc();
    load = 1'b0; count_en = 1'b0;
    chk("clamp", count, 100);
    chk("clamp_term", at_term, 1);
    chk("clamp_cmp", cmp_match, 1);

    // clr beats load and step; set beats ovf_clr
    load_val = 8'd50; load = 1'b1; cyc();
    pre_div = '0; count_clr = 1'b1; count_en = 1'b1; cyc();
    chk("clr_prio", count, 0);
    count_clr = 1'b0; load = 1'b0; count_en = 1'b0; ovf_clr = 1'b1; cyc();
    limit = 8'd0; count_en = 1'b1; cyc();
    chk("set_wins_tick", tick, 1);
    chk("set_wins_ovf", ovf_flag, 1);
    count_en = 1'b0; cyc();
    chk("ovf_clr_alone", ovf_flag, 0);
    ovf_clr = 1'b0;

    // legacy all-ones wrap
    limit = 8'd255; load = 1'b1; load_val = 8'd254; cyc();
    load = 1'b0; count_en = 1'b1; cyc();
    chk("ff_max", count, 255);
    cyc();
    chk("ff_wrap", count, 0);
    chk("ff_tick", tick, 1);

    // reset mid-count restarts the prescaler phase
    pre_div = 4'd3; load = 1'b1; load_val = 8'd37; cyc();
    load = 1'b0; cyc(); cyc();
    rst = 1'b1; cyc();
    chk("midrst_count", count, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("midrst_wait", count, 0);
    cyc();
    chk("midrst_first", count, 1);

    // randomized mix against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      count_en  = ($urandom_range(0, 3) != 0);
      count_clr = ($urandom_range(0, 39) == 0);
      load      = ($urandom_range(0, 19) == 0);
      load_val  = CW'($urandom_range(0, 12));
      ovf_clr   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 29) == 0) limit = CW'($urandom_range(0, 9));
      if ($urandom_range(0, 29) == 0) pre_div = PW'($urandom_range(0, 2));
      cmp_val = CW'($urandom_range(0, 9));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
